// File: rtl/rd_sdram_pkg.sv
// Frame layout and state encodings shared by the SDRAM read and write stages.
// Both sides must agree on burst sizes and the row/column address split.
package rd_sdram_pkg;

    localparam int BURST_LEN       = 256;
    localparam int TAIL_LEN        = 32;
    localparam int BURSTS_PER_LINE = 4;
    localparam int LINES_PER_FRAME = 576;
    localparam int FIFO_DEPTH      = 512;

    localparam int COL_BITS = 8;
    localparam int ROW_W    = 14;
    localparam int ADDR_W   = ROW_W + COL_BITS;
    localparam int LINE_W   = 10;
    localparam int BCNT_W   = 2;
    localparam int LEN_W    = 9;
    localparam int LVL_W    = 10;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        RD_REQ = 5'b00010,
        BURST  = 5'b00100,
        NOP    = 5'b01000,
        DONE   = 5'b10000
    } state_t;

endpackage

// File: rtl/rd_sdram_addr_gen.sv
// Row, burst-in-line and line counters for the frame read-back walk.
// Exposes the current row plus last-burst and last-line flags.
module rd_sdram_addr_gen
    import rd_sdram_pkg::*;
#(
    parameter int BURSTS = BURSTS_PER_LINE,
    parameter int LINES  = LINES_PER_FRAME
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic             last_burst,
    output logic             last_line
);

    logic [BCNT_W-1:0] burst_cnt;
    logic [LINE_W-1:0] line_cnt;

    assign last_burst = (burst_cnt == BCNT_W'(BURSTS - 1));
    assign last_line  = (line_cnt == LINE_W'(LINES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row       <= '0;
            burst_cnt <= '0;
            line_cnt  <= '0;
        end else if (clear) begin
            row       <= '0;
            burst_cnt <= '0;
            line_cnt  <= '0;
        end else if (advance) begin
            row <= row + 1'b1;
            if (last_burst) begin
                burst_cnt <= '0;
                line_cnt  <= line_cnt + 1'b1;
            end else begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_sdram.sv
// Reads the stored frame back from SDRAM one row-burst at a time and
// streams the words into the display FIFO, throttled on FIFO free space.
module rd_sdram
    import rd_sdram_pkg::*;
#(
    parameter int BURST_LEN_P = BURST_LEN,
    parameter int TAIL_LEN_P  = TAIL_LEN,
    parameter int BURSTS_P    = BURSTS_PER_LINE,
    parameter int LINES_P     = LINES_PER_FRAME,
    parameter int DEPTH_P     = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_neg,
    input  logic [LVL_W-1:0]  wrusedw_fifo,
    output logic              rd_req,
    input  logic              rd_ack,
    input  logic              rd_data_valid,
    input  logic [15:0]       rd_data,
    output logic [LEN_W-1:0]  burst_length,
    output logic [ADDR_W-1:0] burst_address,
    output logic              wr_en_fifo,
    output logic [15:0]       wr_data_fifo,
    output logic              frame_done
);

    state_t             state, state_n;
    logic               rd_req_n, done_n;
    logic               pend, pend_n;
    logic [LEN_W-1:0]   len_n, remaining, rem_n, cur_len;
    logic [ADDR_W-1:0]  addr_n;
    logic [LVL_W-1:0]   free;
    logic               clear, advance;
    logic [ROW_W-1:0]   row;
    logic               last_burst, last_line;

    rd_sdram_addr_gen #(
        .BURSTS (BURSTS_P),
        .LINES  (LINES_P)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .advance    (advance),
        .row        (row),
        .last_burst (last_burst),
        .last_line  (last_line)
    );

    assign cur_len = last_burst ? LEN_W'(TAIL_LEN_P) : LEN_W'(BURST_LEN_P);
    assign free    = LVL_W'(DEPTH_P) - wrusedw_fifo;

    // Words arriving after a restart request still drain but are dropped.
    assign wr_en_fifo   = rd_data_valid & (state == BURST) & ~pend;
    assign wr_data_fifo = rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rd_req        <= 1'b0;
            frame_done    <= 1'b0;
            burst_length  <= LEN_W'(BURST_LEN_P);
            burst_address <= '0;
            remaining     <= '0;
            pend          <= 1'b0;
        end else begin
            state         <= state_n;
            rd_req        <= rd_req_n;
            frame_done    <= done_n;
            burst_length  <= len_n;
            burst_address <= addr_n;
            remaining     <= rem_n;
            pend          <= pend_n;
        end
    end

    always_comb begin
        state_n  = state;
        rd_req_n = rd_req;
        done_n   = 1'b0;
        len_n    = burst_length;
        addr_n   = burst_address;
        rem_n    = remaining;
        pend_n   = pend;
        clear    = 1'b0;
        advance  = 1'b0;
        unique case (state)
            IDLE: begin
                len_n = cur_len;
                if (vs_neg) begin
                    clear = 1'b1;
                end else if (free >= {1'b0, cur_len}) begin
                    state_n  = RD_REQ;
                    rd_req_n = 1'b1;
                    addr_n   = {row, {COL_BITS{1'b0}}};
                    rem_n    = cur_len;
                end
            end
            RD_REQ: begin
                if (vs_neg) pend_n = 1'b1;
                if (rd_ack) begin
                    rd_req_n = 1'b0;
                    state_n  = BURST;
                end
            end
            BURST: begin
                if (vs_neg) pend_n = 1'b1;
                if (rd_data_valid) begin
                    rem_n = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) state_n = NOP;
                end
            end
            NOP: begin
                state_n = IDLE;
                if (vs_neg || pend) begin
                    clear  = 1'b1;
                    pend_n = 1'b0;
                end else begin
                    advance = 1'b1;
                    if (last_burst && last_line) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (vs_neg) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rd_sdram.sv
// Randomized bench for rd_sdram with a burst-index reference model.
// Runs a shortened frame (3 lines) so a whole frame fits the cycle budget.
module tb_rd_sdram;

    localparam int LPF  = 3;
    localparam int BPL  = 4;
    localparam int FULL = 256;
    localparam int TAIL = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_neg;
    logic [9:0]  wrusedw_fifo;
    logic        rd_req;
    logic        rd_ack;
    logic        rd_data_valid;
    logic [15:0] rd_data;
    logic [8:0]  burst_length;
    logic [21:0] burst_address;
    logic        wr_en_fifo;
    logic [15:0] wr_data_fifo;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int k        = 0;
    int fd_seen  = 0;

    rd_sdram #(.LINES_P(LPF)) dut (
        .clk           (clk),
        .reset         (reset),
        .vs_neg        (vs_neg),
        .wrusedw_fifo  (wrusedw_fifo),
        .rd_req        (rd_req),
        .rd_ack        (rd_ack),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .burst_length  (burst_length),
        .burst_address (burst_address),
        .wr_en_fifo    (wr_en_fifo),
        .wr_data_fifo  (wr_data_fifo),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

    // Burst k of a frame is stored in SDRAM row k; every 4th is the tail.
    function automatic int exp_len(input int idx);
        return (idx % BPL == BPL - 1) ? TAIL : FULL;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: got rd_req=0 want 1 (burst %0d)", k);
        end
    endtask

    task automatic run_burst(input int ack_dly, input int gap, input int vs_word);
        bit   ok;
        int   len, sent, writes, bad, cyc, exp_w;
        logic v;
        len = exp_len(k);
        wait_req(ok);
        if (!ok) return;
        checks++;
        if (burst_address !== 22'(k * 256)) begin
            failures++;
            $display("FAIL addr: got %h want %h", burst_address, 22'(k * 256));
        end
        checks++;
        if (burst_length !== 9'(len)) begin
            failures++;
            $display("FAIL len: got %0d want %0d", burst_length, len);
        end
        repeat (ack_dly) @(negedge clk);
        checks++;
        if (rd_req !== 1'b1) begin
            failures++;
            $display("FAIL req_hold: got %b want 1", rd_req);
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        checks++;
        if (rd_req !== 1'b0) begin
            failures++;
            $display("FAIL req_drop: got %b want 0", rd_req);
        end
        sent = 0; writes = 0; bad = 0; cyc = 0;
        while (sent < len) begin
            if (gap == 0 || cyc >= 3 * len) v = 1'b1;
            else if (gap == 1) v = (cyc % 2 == 1);
            else v = ($urandom_range(0, 3) != 0);
            rd_data_valid = v;
            rd_data       = 16'($urandom);
            vs_neg        = v && (sent + 1 == vs_word);
            #1;
            if (wr_en_fifo === 1'b1) begin
                writes++;
                if (wr_data_fifo !== rd_data) bad++;
            end
            if (v) sent++;
            cyc++;
            @(negedge clk);
        end
        vs_neg        = 1'b0;
        rd_data_valid = 1'b1;
        #1;
        checks++;
        if (wr_en_fifo !== 1'b0) begin
            failures++;
            $display("FAIL post_burst_wr: got %b want 0", wr_en_fifo);
        end
        rd_data_valid = 1'b0;
        exp_w = (vs_word > 0) ? vs_word : len;
        checks++;
        if (writes !== exp_w) begin
            failures++;
            $display("FAIL writes: got %0d want %0d", writes, exp_w);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL wr_data: got %0d bad words want 0", bad);
        end
        k = (vs_word > 0) ? 0 : k + 1;
        @(negedge clk);
        checks++;
        if (frame_done !== (k == BPL * LPF)) begin
            failures++;
            $display("FAIL frame_done: got %b want %b", frame_done, k == BPL * LPF);
        end
        if (k == BPL * LPF) begin
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0) begin
                failures++;
                $display("FAIL frame_done_pulse: got %b want 0", frame_done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; vs_neg = 1'b0; rd_ack = 1'b0;
        rd_data_valid = 1'b1; rd_data = 16'h1234;
        wrusedw_fifo = 10'd257;
        repeat (2) @(negedge clk);
        checks += 5;
        if (rd_req !== 1'b0) begin
            failures++; $display("FAIL rst_req: got %b want 0", rd_req);
        end
        if (wr_en_fifo !== 1'b0) begin
            failures++; $display("FAIL rst_wr: got %b want 0", wr_en_fifo);
        end
        if (frame_done !== 1'b0) begin
            failures++; $display("FAIL rst_fd: got %b want 0", frame_done);
        end
        if (burst_length !== 9'd256) begin
            failures++; $display("FAIL rst_len: got %0d want 256", burst_length);
        end
        if (burst_address !== 22'd0) begin
            failures++; $display("FAIL rst_addr: got %h want 0", burst_address);
        end
        rd_data_valid = 1'b0;
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_threshold();
        int seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL thr_below: got %0d reqs want 0", seen);
        end
        wrusedw_fifo = 10'd256;
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b1) begin
            failures++; $display("FAIL thr_equal: got %b want 1", rd_req);
        end
        wrusedw_fifo = 10'd0;
    endtask

    task automatic test_first_burst();
        run_burst(3, 0, 0);
    endtask

    task automatic test_line();
        for (int i = 0; i < 4; i++) run_burst($urandom_range(0, 4), 2, 0);
    endtask

    task automatic test_restart();
        run_burst(2, 0, 100);
    endtask

    task automatic test_gaps();
        run_burst(1, 1, 0);
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int writes = 0;
        wait_req(ok);
        if (!ok) return;
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        repeat (50) begin
            rd_data_valid = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        repeat (20) begin
            rd_data = 16'($urandom);
            #1;
            if (wr_en_fifo === 1'b1) writes++;
            @(negedge clk);
        end
        checks += 2;
        if (writes !== 0) begin
            failures++; $display("FAIL rst_mid_wr: got %0d want 0", writes);
        end
        if (rd_req !== 1'b0) begin
            failures++; $display("FAIL rst_mid_req: got %b want 0", rd_req);
        end
        rd_data_valid = 1'b0;
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_full_frame();
        while (k < BPL * LPF) run_burst($urandom_range(0, 3), 2, 0);
    endtask

    task automatic test_done_hold();
        int seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL done_req: got %0d reqs want 0", seen);
        end
        checks++;
        if (fd_seen !== 1) begin
            failures++; $display("FAIL fd_count: got %0d want 1", fd_seen);
        end
        vs_neg = 1'b1;
        @(negedge clk);
        vs_neg = 1'b0;
        k = 0;
        run_burst(0, 2, 0);
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_first_burst();
        test_line();
        test_restart();
        test_gaps();
        test_reset_midburst();
        test_full_frame();
        test_done_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_sdram.md
Name: rd_sdram

Overview:
Downstream counterpart of the SDRAM write stage. Reads the stored PAL frame back from SDRAM in bursts, using the same row layout the writer uses: one burst per SDRAM row, 256-word rows, and each line made of 3 full bursts plus 1 tail burst. It pushes the returned 16-bit pixels into the display-side FIFO. It throttles on FIFO free space and restarts at every display frame start.

Parameters:
BURST_LEN, 256, words per full burst (one SDRAM row)
TAIL_LEN, 32, words in the last burst of each line
BURSTS_PER_LINE, 4, bursts per line; the last one is the tail
LINES_PER_FRAME, 576, lines read per frame
FIFO_DEPTH, 512, capacity of the display FIFO in words

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  asynchronous, active-high reset
vs_neg  in  1  one-cycle pulse at display frame start; synchronous restart
wrusedw_fifo  in  10  display FIFO fill level, 0..512
rd_req  out  1  burst read request to the SDRAM controller
rd_ack  in  1  controller grant; one-cycle pulse
rd_data_valid  in  1  qualifies rd_data during a burst
rd_data  in  16  read data from the controller
burst_length  out  9  words in the requested burst
burst_address  out  22  {row[13:0], 8'b0}
wr_en_fifo  out  1  display FIFO write enable
wr_data_fifo  out  16  display FIFO write data
frame_done  out  1  one-cycle pulse after the last burst of the frame

Behaviour:
- Reset values:
  - State = IDLE.
  - rd_req, wr_en_fifo, frame_done = 0.
  - burst_length = BURST_LEN, burst_address = 0.
  - Row, burst, line and remaining counters = 0; restart_pend = 0.
- States: IDLE, RD_REQ, BURST, NOP, DONE (one-hot).
- Current burst length:
  - TAIL_LEN when burst_cnt == BURSTS_PER_LINE-1, else BURST_LEN.
  - burst_length is updated every cycle while in IDLE.
- IDLE -> RD_REQ when (FIFO_DEPTH - wrusedw_fifo) >= current burst length, computed unsigned at 10 bits.
  - On this transition: rd_req <= 1, burst_address <= {row, 8'b0}, remaining <= burst_length.
- RD_REQ:
  - rd_req is held at 1 until rd_ack.
  - On rd_ack: rd_req <= 0 and go to BURST. There is no timeout.
- BURST:
  - wr_en_fifo = rd_data_valid & (state == BURST) & ~restart_pend. This is combinational with zero latency; wr_data_fifo = rd_data.
  - Each valid word decrements remaining.
  - A valid word while remaining == 1 goes to NOP.
  - Gaps in rd_data_valid are allowed.
- NOP (one cycle):
  - row increments, wrapping at 14 bits.
  - burst_cnt increments and wraps to 0 after BURSTS_PER_LINE-1.
  - On that wrap, line_cnt increments.
  - If the line just completed was line LINES_PER_FRAME-1: go to DONE and pulse frame_done. Otherwise go to IDLE.
- DONE: issues no requests and holds until vs_neg.
- vs_neg handling:
  - In IDLE, NOP or DONE: the next state is IDLE, and row, burst_cnt and line_cnt are cleared. frame_done is suppressed if it coincides.
  - In RD_REQ or BURST: set restart_pend. The burst runs to completion with its data discarded (wr_en_fifo held low). The counter clear is then applied in NOP, which goes to IDLE and clears restart_pend.
  - vs_neg while restart_pend is already set has no further effect.
- reset asserted mid-burst: everything returns to reset values immediately. Words the controller is still delivering are ignored because the state is not BURST.
- FIFO exactly at threshold: free == burst length is a request; free == burst length - 1 is not.
- Free space is sampled only in IDLE. The FIFO cannot overflow because only this block writes it.

Decomposition:
- Shared package/include (mydefines):
  - State encodings.
  - BURST_LEN, TAIL_LEN, BURSTS_PER_LINE, LINES_PER_FRAME.
  - Address layout constant: 8 column bits.
  These are shared with the write stage so both sides agree on the frame layout.
- One natural sub-module: rd_sdram_addr_gen, holding the row, burst_cnt and line_cnt counters plus the last-burst/last-line flags. The FSM stays in the top.

Test Plan:
1. After reset, wrusedw = 0, ack after 3 cycles, 256 valid words -> one rd_req; burst_address = 0, burst_length = 256; 256 FIFO writes; next burst_address = 0x000100.
2. Fourth burst of a line -> burst_length = 32, burst_address = 0x000300; after it, burst_cnt = 0 and line_cnt = 1.
3. wrusedw = 257 in IDLE -> no rd_req; drop to 256 -> rd_req on the next cycle.
4. vs_neg at word 100 of a burst -> remaining 156 words produce no wr_en_fifo; then IDLE with next burst_address = 0.
5. Full frame of 576×4 bursts -> single frame_done pulse; DONE issues no rd_req until vs_neg.
6. rd_data_valid toggling every other cycle -> exactly burst_length writes; no early NOP.
